uart_core: RTL and testbench

UART_CORE -- requirements
Module: uart_core

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx.sv | 104 ++++++++++
 rtl/uart_core.sv | 137 +++++++++++++
 tb/tb_uart_core.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, FSM state encodings and parity helper.
// Pure declarations; no logic, latency or flow control of its own.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Callers zero-extend narrower words to 9 bits; the extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [8:0] d, input int mode);
    return (^d) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmit serializer: start, LSB-first data, optional parity, stop bits, DIV cycles each.
// Start bit appears the cycle after acceptance; tx_ready is high only while idle.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DIV       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 serial_tx
);

  localparam int             TW     = $clog2(DIV);
  localparam logic [TW-1:0]  RELOAD = TW'(DIV - 1);
  localparam logic [3:0]     N_DATA = 4'(DATA_BITS);
  localparam logic [3:0]     N_STOP = 4'(STOP_BITS);

  logic [2:0]           r_state;
  logic [TW-1:0]        r_timer;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (tx_valid && r_ready) begin
            r_shift <= tx_data;
            r_par   <= parity_bit(9'(tx_data), PARITY);
            r_tx    <= 1'b0;
            r_timer <= RELOAD;
            r_state <= ST_START;
            r_ready <= 1'b0;
          end else begin
            r_ready <= 1'b1;
          end
        end
        default: begin
          if (r_timer != '0) begin
            r_timer <= r_timer - TW'(1);
          end else begin
            r_timer <= RELOAD;
            case (r_state)
              ST_START: begin
                r_tx    <= r_shift[0];
                r_shift <= r_shift >> 1;
                r_bit   <= 4'd1;
                r_state <= ST_DATA;
              end
              ST_DATA: begin
                if (r_bit != N_DATA) begin
                  r_tx    <= r_shift[0];
                  r_shift <= r_shift >> 1;
                  r_bit   <= r_bit + 4'd1;
                end else if (PARITY != PAR_NONE) begin
                  r_tx    <= r_par;
                  r_state <= ST_PARITY;
                end else begin
                  r_tx    <= 1'b1;
                  r_bit   <= 4'd1;
                  r_state <= ST_STOP;
                end
              end
              ST_PARITY: begin
                r_tx    <= 1'b1;
                r_bit   <= 4'd1;
                r_state <= ST_STOP;
              end
              default: begin
                if (r_bit != N_STOP) begin
                  r_bit <= r_bit + 4'd1;
                end else begin
                  r_state <= ST_IDLE;
                  r_ready <= 1'b1;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

  assign tx_ready  = r_ready;
  assign serial_tx = r_tx;

endmodule

// File: rtl/uart_core.sv
// UART with registered transmitter and centre-sampling receiver behind a 2-flop synchronizer.
// rx_valid holds until rx_ready; a frame landing on an unconsumed word overwrites it and pulses rx_overrun.
module uart_core
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ  = 12_000_000,
  parameter int BAUD_HZ   = 9_600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 serial_rx,
  output logic                 serial_tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  localparam int DIV = CLOCK_HZ / BAUD_HZ;

  if (DIV < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
    $error("uart_core: illegal parameter combination");
  end

  localparam int            TW       = $clog2(DIV);
  localparam logic [TW-1:0] RELOAD   = TW'(DIV - 1);
  localparam logic [TW-1:0] HALF     = TW'(DIV / 2 - 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

  uart_tx #(
    .DIV       (DIV),
    .DATA_BITS (DATA_BITS),
    .PARITY    (PARITY),
    .STOP_BITS (STOP_BITS)
  ) u_tx (
    .clock     (clock),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .serial_tx (serial_tx)
  );

  logic                 r_sync1, r_sync2;
  logic [2:0]           r_rx_state;
  logic [TW-1:0]        r_rx_timer;
  logic [3:0]           r_rx_bit;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_par_bad;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid, r_frame_err, r_parity_err, r_overrun;
  logic                 w_rx;

  assign w_rx = r_sync2;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_rx_state   <= ST_IDLE;
      r_rx_timer   <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_par_bad    <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_sync1   <= serial_rx;
      r_sync2   <= r_sync1;
      r_overrun <= 1'b0;
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
      case (r_rx_state)
        ST_IDLE: begin
          if (!w_rx) begin
            r_rx_state <= ST_START;
            r_rx_timer <= HALF;
          end
        end
        default: begin
          if (r_rx_timer != '0) begin
            r_rx_timer <= r_rx_timer - TW'(1);
          end else begin
            r_rx_timer <= RELOAD;
            case (r_rx_state)
              ST_START: begin
                // High at the start-bit centre means a glitch, not a frame.
                if (w_rx) begin
                  r_rx_state <= ST_IDLE;
                end else begin
                  r_rx_state <= ST_DATA;
                  r_rx_bit   <= '0;
                end
              end
              ST_DATA: begin
                r_rx_shift <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
                r_rx_bit   <= r_rx_bit + 4'd1;
                if (r_rx_bit == LAST_BIT)
                  r_rx_state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
              end
              ST_PARITY: begin
                r_par_bad  <= w_rx != parity_bit(9'(r_rx_shift), PARITY);
                r_rx_state <= ST_STOP;
              end
              default: begin
                r_rx_data    <= r_rx_shift;
                r_frame_err  <= !w_rx;
                r_parity_err <= (PARITY != PAR_NONE) && r_par_bad;
                r_rx_valid   <= 1'b1;
                r_overrun    <= r_rx_valid && !rx_ready;
                r_rx_state   <= ST_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_valid      = r_rx_valid;
  assign rx_frame_err  = r_frame_err;
  assign rx_parity_err = r_parity_err;
  assign rx_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core at DIV=16: 8N1, 8E1 loopback and 8O1 instances against a frame-level model.
module tb_uart_core;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic rx_line = 1'b1;
  int   rx_sel  = 0;
  logic srx0, srx2;
  assign srx0 = (rx_sel == 0) ? rx_line : 1'b1;
  assign srx2 = (rx_sel == 2) ? rx_line : 1'b1;

  logic       tx0, txv0 = 1'b0, txr0, rxv0, rxr0 = 1'b0, fe0, pe0, ov0;
  logic [7:0] txd0 = 8'h00, rxd0;
  logic       tx1, txv1 = 1'b0, txr1, rxv1, fe1, pe1, ov1;
  logic [7:0] txd1 = 8'h00, rxd1;
  logic       tx2, txr2, rxv2, rxr2 = 1'b0, fe2, pe2, ov2;
  logic [7:0] rxd2;

  uart_core #(.CLOCK_HZ(CLK_HZ), .BAUD_HZ(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clock(clk), .reset(rst), .serial_rx(srx0), .serial_tx(tx0),
    .tx_data(txd0), .tx_valid(txv0), .tx_ready(txr0),
    .rx_data(rxd0), .rx_valid(rxv0), .rx_ready(rxr0),
    .rx_frame_err(fe0), .rx_parity_err(pe0), .rx_overrun(ov0));

  uart_core #(.CLOCK_HZ(CLK_HZ), .BAUD_HZ(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut1 (
    .clock(clk), .reset(rst), .serial_rx(tx1), .serial_tx(tx1),
    .tx_data(txd1), .tx_valid(txv1), .tx_ready(txr1),
    .rx_data(rxd1), .rx_valid(rxv1), .rx_ready(1'b1),
    .rx_frame_err(fe1), .rx_parity_err(pe1), .rx_overrun(ov1));

  uart_core #(.CLOCK_HZ(CLK_HZ), .BAUD_HZ(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut2 (
    .clock(clk), .reset(rst), .serial_rx(srx2), .serial_tx(tx2),
    .tx_data(8'h00), .tx_valid(1'b0), .tx_ready(txr2),
    .rx_data(rxd2), .rx_valid(rxv2), .rx_ready(rxr2),
    .rx_frame_err(fe2), .rx_parity_err(pe2), .rx_overrun(ov2));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Frame as it appears on the wire, element 0 first.
  task automatic make_frame(input logic [7:0] d, input int mode, input logic par_flip,
                            input logic stop_val, output logic [15:0] f, output int n);
    int ones;
    ones = $countones(d);
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    n = 9;
    if (mode != 0) begin
      f[n] = ((mode == 1) ? (ones % 2 == 1) : (ones % 2 == 0)) ^ par_flip;
      n = n + 1;
    end
    f[n] = stop_val;
    n = n + 1;
  endtask

  task automatic send_frame(input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      rx_line = f[i];
      repeat (DIV) tick;
    end
    rx_line = 1'b1;
  endtask

  task automatic wait_txr0;
    for (int b = 0; b < 400 && !txr0; b++) tick;
    chk("tx0_ready_wait", txr0, 1);
  endtask

  task automatic tx0_frame_check(input logic [7:0] d);
    logic [15:0] f;
    int n;
    make_frame(d, 0, 1'b0, 1'b1, f, n);
    wait_txr0();
    txd0 = d;
    txv0 = 1'b1;
    tick;
    txv0 = 1'b0;
    for (int j = 0; j < n * DIV; j++) begin
      chk("tx_bit", tx0, f[j/DIV]);
      chk("tx_busy_ready", txr0, 0);
      tick;
    end
    chk("tx_ready_back", txr0, 1);
    chk("tx_idle_line", tx0, 1);
  endtask

  task automatic rx0_case(input logic [7:0] d, input logic stop_ok);
    logic [15:0] f;
    int n;
    make_frame(d, 0, 1'b0, stop_ok, f, n);
    send_frame(f, n);
    repeat (4) tick;
    chk("rx0_valid", rxv0, 1);
    chk("rx0_data", rxd0, d);
    chk("rx0_frame_err", fe0, !stop_ok);
    chk("rx0_parity_err", pe0, 0);
    repeat (3) tick;
    chk("rx0_valid_hold", rxv0, 1);
    rxr0 = 1'b1;
    tick;
    rxr0 = 1'b0;
    chk("rx0_valid_clear", rxv0, 0);
    repeat (24) tick;
  endtask

  task automatic rx2_case(input logic [7:0] d, input logic flip);
    logic [15:0] f;
    int n;
    make_frame(d, 2, flip, 1'b1, f, n);
    send_frame(f, n);
    repeat (4) tick;
    chk("rx2_valid", rxv2, 1);
    chk("rx2_data", rxd2, d);
    chk("rx2_parity_err", pe2, flip);
    chk("rx2_frame_err", fe2, 0);
    rxr2 = 1'b1;
    tick;
    rxr2 = 1'b0;
    repeat (24) tick;
  endtask

  logic [7:0] lb_q[$];
  int lb_rx = 0;
  int ov0_cnt = 0;

  always @(negedge clk) begin
    if (!rst && ov0) ov0_cnt++;
    if (!rst && rxv1) begin
      if (lb_q.size() == 0) begin
        chk("lb_extra_word", lb_q.size(), 1);
      end else begin
        logic [7:0] e;
        e = lb_q.pop_front();
        chk("lb_data", rxd1, e);
        chk("lb_frame_err", fe1, 0);
        chk("lb_parity_err", pe1, 0);
        lb_rx++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] words[8];
    logic [7:0] d;
    logic [15:0] f;
    int n;

    repeat (3) tick;
    chk("rst_serial_tx", tx0, 1);
    chk("rst_tx_ready", txr0, 0);
    chk("rst_tx_ready1", txr1, 0);
    chk("rst_rx_valid", rxv0, 0);
    chk("rst_rx_data", rxd0, 0);
    chk("rst_flags", {fe0, pe0, ov0, ov1, ov2}, 0);
    chk("rst_serial_tx2", tx2, 1);
    rst = 1'b0;
    tick;
    chk("rel_tx_ready", txr0, 1);
    chk("rel_tx_ready2", txr2, 1);

    // Transmit timing: 0x41 first, then random words.
    tx0_frame_check(8'h41);
    for (int k = 0; k < 2; k++) tx0_frame_check(8'($urandom));

    // Loopback with even parity, words offered back to back.
    words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'hA5;
    for (int k = 3; k < 8; k++) words[k] = 8'($urandom);
    txv1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      txd1 = words[k];
      for (int b = 0; b < 400 && !txr1; b++) tick;
      chk("lb_tx_ready_wait", txr1, 1);
      lb_q.push_back(words[k]);
      tick;
    end
    txv1 = 1'b0;
    for (int b = 0; b < 3000 && lb_q.size() > 0; b++) tick;
    repeat (4) tick;
    chk("lb_drain", lb_q.size(), 0);
    chk("lb_count", lb_rx, 8);

    // Short low glitch on the receive line must not start a frame.
    rx_sel = 0;
    rx_line = 1'b0;
    repeat (4) tick;
    rx_line = 1'b1;
    for (int j = 0; j < 40; j++) begin
      chk("glitch_no_valid", rxv0, 0);
      tick;
    end
    rx0_case(8'h5A, 1'b1);
    rx0_case(8'h3C, 1'b0);
    for (int k = 0; k < 6; k++) rx0_case(8'($urandom), ($urandom % 4) != 0);

    // Overrun: two frames without consuming.
    ov0_cnt = 0;
    make_frame(8'h11, 0, 1'b0, 1'b1, f, n);
    send_frame(f, n);
    repeat (4) tick;
    chk("ovr_first_data", rxd0, 8'h11);
    chk("ovr_none_yet", ov0_cnt, 0);
    make_frame(8'h22, 0, 1'b0, 1'b1, f, n);
    send_frame(f, n);
    repeat (4) tick;
    chk("ovr_pulses", ov0_cnt, 1);
    chk("ovr_valid", rxv0, 1);
    chk("ovr_data", rxd0, 8'h22);
    rxr0 = 1'b1;
    tick;
    rxr0 = 1'b0;
    chk("ovr_clear", rxv0, 0);

    // Odd parity receiver: flipped and correct parity.
    rx_sel = 2;
    rx2_case(8'h3C, 1'b1);
    rx2_case(8'($urandom), 1'b0);
    rx_sel = 0;

    // Reset in the middle of a transmit frame.
    d = 8'($urandom) & 8'hFB;
    make_frame(d, 0, 1'b0, 1'b1, f, n);
    wait_txr0();
    txd0 = d;
    txv0 = 1'b1;
    tick;
    txv0 = 1'b0;
    repeat (50) tick;
    chk("mid_tx_bit", tx0, f[50/DIV]);
    rst = 1'b1;
    tick;
    chk("mid_rst_tx", tx0, 1);
    chk("mid_rst_ready", txr0, 0);
    tick;
    chk("mid_rst_ready_hold", txr0, 0);
    chk("mid_rst_rx_data", rxd0, 0);
    rst = 1'b0;
    tick;
    chk("mid_rel_ready", txr0, 1);
    chk("mid_rel_tx", tx0, 1);
    chk("mid_rel_rx_valid", rxv0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
